// File: rtl/h264_pkg.sv
`default_nettype none
// ============================================================================
// Module      : h264_pkg
// Description : Shared types and constants for the H.264 luma intra 4x4 path.
//               Holds the intra 4x4 mode encoding, default sample/residual
//               widths, the DC fallback value and the pixel clip helper.
// Revision    : 1.0 - initial release
// ============================================================================
package h264_pkg;

  typedef enum logic [1:0] {
    VERT  = 2'd0,
    HORIZ = 2'd1,
    DC    = 2'd2,
    RSVD  = 2'd3
  } intra4x4_mode_t;

  localparam int PIX_W_DEFAULT = 8;
  localparam int RES_W_DEFAULT = 9;
  localparam int DC_DEFAULT    = 128;

  // Saturate a signed value to [0, max_value].
  function automatic int clip_pix(input int value, input int max_value);
    if (value < 0) begin
      return 0;
    end else if (value > max_value) begin
      return max_value;
    end else begin
      return value;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/intra4x4_predictor.sv
`default_nettype none
// ============================================================================
// Module      : intra4x4_predictor
// Description : Combinational intra 4x4 luma predictor.
//               Computes the DC value from the supplied neighbours and the
//               prediction for sample (row, col) of the current block.
// Ports       : mode        - intra mode (VERT/HORIZ/DC/RSVD)
//               top, left   - four neighbour samples each, index 0 in LSBs
//               top_avail   - top neighbours exist
//               left_avail  - left neighbours exist
//               row, col    - sample position within the block
//               dc_in       - DC value registered by the parent
//               dc          - DC value derived from top/left
//               pred        - prediction for (row, col)
// Revision    : 1.0 - initial release
// ============================================================================
module intra4x4_predictor
  import h264_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic [1:0]         mode,
  input  logic [4*PIX_W-1:0] top,
  input  logic [4*PIX_W-1:0] left,
  input  logic               top_avail,
  input  logic               left_avail,
  input  logic [1:0]         row,
  input  logic [1:0]         col,
  input  logic [PIX_W-1:0]   dc_in,
  output logic [PIX_W-1:0]   dc,
  output logic [PIX_W-1:0]   pred
);

  localparam logic [PIX_W-1:0] c_dc_default = PIX_W'(DC_DEFAULT);
  // Eight samples plus rounding fit in PIX_W+3 bits.
  localparam int SUM_W = PIX_W + 3;

  logic [SUM_W-1:0] w_sum_top;
  logic [SUM_W-1:0] w_sum_left;
  logic [PIX_W-1:0] w_dc_both;
  logic [PIX_W-1:0] w_dc_top;
  logic [PIX_W-1:0] w_dc_left;

  always_comb begin
    w_sum_top  = '0;
    w_sum_left = '0;
    for (int i = 0; i < 4; i++) begin
      w_sum_top  = w_sum_top  + SUM_W'(top[i*PIX_W +: PIX_W]);
      w_sum_left = w_sum_left + SUM_W'(left[i*PIX_W +: PIX_W]);
    end
  end

  assign w_dc_both = PIX_W'((w_sum_top + w_sum_left + SUM_W'(4)) >> 3);
  assign w_dc_top  = PIX_W'((w_sum_top + SUM_W'(2)) >> 2);
  assign w_dc_left = PIX_W'((w_sum_left + SUM_W'(2)) >> 2);

  always_comb begin
    dc = c_dc_default;
    if (top_avail && left_avail) begin
      dc = w_dc_both;
    end else if (top_avail) begin
      dc = w_dc_top;
    end else if (left_avail) begin
      dc = w_dc_left;
    end
  end

  // Directional modes fall back to the mid-grey value when their
  // neighbours lie outside the macroblock.
  always_comb begin
    pred = dc_in;
    case (intra4x4_mode_t'(mode))
      VERT:    pred = top_avail  ? top[int'(col)*PIX_W +: PIX_W]  : c_dc_default;
      HORIZ:   pred = left_avail ? left[int'(row)*PIX_W +: PIX_W] : c_dc_default;
      default: pred = dc_in;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/decoder_intra4x4.sv
`default_nettype none
// ============================================================================
// Module      : decoder_intra4x4
// Description : Luma intra 4x4 reconstruction of one 16x16 macroblock.
//               Per block: accept a mode header, sample neighbours, add 16
//               residuals to the prediction, clip and stream pixels out.
// Ports       : clk, reset (sync, active low)
//               enable                       - start a macroblock (IDLE only)
//               mode_valid/mode/mode_ready   - block header handshake
//               res_valid/res_data/res_ready - residual handshake
//               pix_valid/pix_data/pix_blk/pix_pos - registered pixel output
//               done_luma4x4                 - pulse when block 15 completes
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_intra4x4
  import h264_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT,
  parameter int RES_W = RES_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             mode_valid,
  input  logic [1:0]       mode,
  output logic             mode_ready,
  input  logic             res_valid,
  input  logic [RES_W-1:0] res_data,
  output logic             res_ready,
  output logic             pix_valid,
  output logic [PIX_W-1:0] pix_data,
  output logic [3:0]       pix_blk,
  output logic [3:0]       pix_pos,
  output logic             done_luma4x4
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_PRED = 3'd2;
  localparam logic [2:0] S_RES  = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;

  localparam int PIX_MAX = (1 << PIX_W) - 1;

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [3:0]         r_idx;
  logic [3:0]         r_pos;
  logic [1:0]         r_mode;
  logic [4*PIX_W-1:0] r_top;
  logic [4*PIX_W-1:0] r_left;
  logic [PIX_W-1:0]   r_dc;
  logic [PIX_W-1:0]   r_arr [0:255];
  logic               r_pix_valid;
  logic [PIX_W-1:0]   r_pix_data;
  logic [3:0]         r_pix_blk;
  logic [3:0]         r_pix_pos;

  logic               w_mode_ready;
  logic               w_res_ready;
  logic               w_done;
  logic               w_mode_hs;
  logic               w_res_hs;
  logic [1:0]         w_blk_x;
  logic [1:0]         w_blk_y;
  logic               w_top_avail;
  logic               w_left_avail;
  logic [4*PIX_W-1:0] w_top_rd;
  logic [4*PIX_W-1:0] w_left_rd;
  logic [4*PIX_W-1:0] w_top_sel;
  logic [4*PIX_W-1:0] w_left_sel;
  logic [PIX_W-1:0]   w_dc;
  logic [PIX_W-1:0]   w_pred;
  logic [7:0]         w_wr_addr;
  logic signed [RES_W:0] w_sum;
  logic [PIX_W-1:0]   w_recon;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (enable)    w_state_next = S_HDR;
      S_HDR:  if (w_mode_hs) w_state_next = S_PRED;
      S_PRED: w_state_next = S_RES;
      S_RES:  if (w_res_hs && (r_pos == 4'd15)) w_state_next = S_NEXT;
      S_NEXT: w_state_next = (r_idx == 4'd15) ? S_IDLE : S_HDR;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_mode_ready = 1'b0;
    w_res_ready  = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_HDR:   w_mode_ready = 1'b1;
      S_RES:   w_res_ready  = 1'b1;
      S_NEXT:  w_done       = (r_idx == 4'd15);
      default: ;
    endcase
  end

  assign w_mode_hs = mode_valid && w_mode_ready;
  assign w_res_hs  = res_valid && w_res_ready;

  // ---------------------------------------------------- neighbour access
  // Array address is {row[3:0], col[3:0]} of the macroblock.
  assign w_blk_x      = r_idx[1:0];
  assign w_blk_y      = r_idx[3:2];
  assign w_top_avail  = (w_blk_y != 2'd0);
  assign w_left_avail = (w_blk_x != 2'd0);
  assign w_wr_addr    = {w_blk_y, r_pos[3:2], w_blk_x, r_pos[1:0]};

  // Out-of-macroblock addresses wrap harmlessly; the availability flags
  // keep those samples out of the prediction.
  always_comb begin
    w_top_rd  = '0;
    w_left_rd = '0;
    for (int i = 0; i < 4; i++) begin
      w_top_rd[i*PIX_W +: PIX_W]  = r_arr[{w_blk_y - 2'd1, 2'b11, w_blk_x, 2'(i)}];
      w_left_rd[i*PIX_W +: PIX_W] = r_arr[{w_blk_y, 2'(i), w_blk_x - 2'd1, 2'b11}];
    end
  end

  // In PRED the predictor sees the live array so its DC output can be
  // captured; in RES it works from the latched neighbours.
  assign w_top_sel  = (r_state == S_PRED) ? w_top_rd  : r_top;
  assign w_left_sel = (r_state == S_PRED) ? w_left_rd : r_left;

  intra4x4_predictor #(
    .PIX_W (PIX_W)
  ) u_pred (
    .mode       (r_mode),
    .top        (w_top_sel),
    .left       (w_left_sel),
    .top_avail  (w_top_avail),
    .left_avail (w_left_avail),
    .row        (r_pos[3:2]),
    .col        (r_pos[1:0]),
    .dc_in      (r_dc),
    .dc         (w_dc),
    .pred       (w_pred)
  );

  // ------------------------------------------------------ reconstruction
  assign w_sum   = $signed({{(RES_W + 1 - PIX_W){1'b0}}, w_pred})
                 + $signed({res_data[RES_W-1], res_data});
  assign w_recon = PIX_W'(clip_pix(int'(w_sum), PIX_MAX));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx       <= '0;
      r_pos       <= '0;
      r_mode      <= '0;
      r_top       <= '0;
      r_left      <= '0;
      r_dc        <= '0;
      r_pix_valid <= 1'b0;
      r_pix_data  <= '0;
      r_pix_blk   <= '0;
      r_pix_pos   <= '0;
      for (int a = 0; a < 256; a++) begin
        r_arr[a] <= '0;
      end
    end else begin
      r_pix_valid <= w_res_hs;
      if ((r_state == S_IDLE) && enable) begin
        r_idx <= '0;
      end
      if (w_mode_hs) begin
        r_mode <= mode;
      end
      if (r_state == S_PRED) begin
        r_top  <= w_top_rd;
        r_left <= w_left_rd;
        r_dc   <= w_dc;
        r_pos  <= '0;
      end
      if (w_res_hs) begin
        r_arr[w_wr_addr] <= w_recon;
        r_pix_data       <= w_recon;
        r_pix_blk        <= r_idx;
        r_pix_pos        <= r_pos;
        r_pos            <= r_pos + 4'd1;
      end
      if ((r_state == S_NEXT) && (r_idx != 4'd15)) begin
        r_idx <= r_idx + 4'd1;
      end
    end
  end

  assign mode_ready   = w_mode_ready;
  assign res_ready    = w_res_ready;
  assign done_luma4x4 = w_done;
  assign pix_valid    = r_pix_valid;
  assign pix_data     = r_pix_data;
  assign pix_blk      = r_pix_blk;
  assign pix_pos      = r_pix_pos;

endmodule
`default_nettype wire

// File: tb/tb_decoder_intra4x4.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_intra4x4
// Description : Self-checking bench for decoder_intra4x4. Directed macroblocks
//               with hand-computed pixel values held in a vector table, plus
//               sequences for stalls, latency and mid-macroblock reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_intra4x4;

  localparam int PIX_W = 8;
  localparam int RES_W = 9;
  localparam int NV    = 20;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             enable = 1'b0;
  logic             mode_valid = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             mode_ready;
  logic             res_valid = 1'b0;
  logic [RES_W-1:0] res_data = '0;
  logic             res_ready;
  logic             pix_valid;
  logic [PIX_W-1:0] pix_data;
  logic [3:0]       pix_blk;
  logic [3:0]       pix_pos;
  logic             done_luma4x4;

  always #5 clk = ~clk;

  decoder_intra4x4 #(
    .PIX_W (PIX_W),
    .RES_W (RES_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .mode_valid   (mode_valid),
    .mode         (mode),
    .mode_ready   (mode_ready),
    .res_valid    (res_valid),
    .res_data     (res_data),
    .res_ready    (res_ready),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_blk      (pix_blk),
    .pix_pos      (pix_pos),
    .done_luma4x4 (done_luma4x4)
  );

  int checks = 0;
  int errors = 0;

  int modes_q [16];
  int res_q   [16][16];
  int cap     [256];
  int ref_cap [256];
  int cyc      = 0;
  int en_cyc   = 0;
  int done_cyc = 0;
  int done_cnt = 0;
  int pix_cnt  = 0;
  int seq      = 0;
  int drv_hs   = 0;
  logic mon_hs;

  typedef struct {
    int    scen;
    string name;
    int    blk;
    int    pos;
    int    exp;
  } vec_t;

  vec_t vtab [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: every pixel must follow a handshake one edge earlier,
  // arrive in block/position order, and done must coincide with pixel 256.
  always @(posedge clk) begin
    mon_hs = res_valid && res_ready && reset;
    cyc++;
    if (enable && reset) en_cyc = cyc;
    #1;
    check("pix_valid_vs_handshake", 32'(pix_valid), 32'(mon_hs));
    if (pix_valid === 1'b1) begin
      cap[{pix_blk, pix_pos}] = int'(pix_data);
      check("pix_order", 32'({pix_blk, pix_pos}), 32'(seq));
      seq++;
      pix_cnt++;
    end
    if (done_luma4x4 === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      check("done_on_last_pix", 32'(seq), 32'd256);
    end
  end

  task automatic set_flat();
    for (int b = 0; b < 16; b++) begin
      modes_q[b] = 2;
      for (int p = 0; p < 16; p++) res_q[b][p] = 0;
    end
  endtask

  task automatic set_vert_cfg();
    set_flat();
    res_q[0][12] = 10; res_q[0][13] = 20; res_q[0][14] = 30; res_q[0][15] = 40;
    modes_q[1] = 1;  // horizontal
    modes_q[2] = 0;  // vertical, no top
    modes_q[4] = 0;  // vertical
    modes_q[5] = 3;  // reserved -> DC
    modes_q[8] = 1;  // horizontal, no left
  endtask

  task automatic set_dc_cfg();
    set_flat();
    for (int p = 0; p < 16; p++) res_q[0][p] = -28;
  endtask

  // Drive one macroblock. abort_blk < 16 pulls reset during that block.
  task automatic run_mb(input bit stall, input int abort_blk);
    int t;
    seq = 0; pix_cnt = 0; done_cnt = 0; drv_hs = 0;
    for (int i = 0; i < 256; i++) cap[i] = -1;
    @(negedge clk); enable = 1'b1;
    @(negedge clk); enable = 1'b0;
    for (int b = 0; b < 16; b++) begin
      t = 0;
      while (!mode_ready && t < 50) begin @(negedge clk); t++; end
      check("mode_ready_wait", 32'(mode_ready), 32'd1);
      if (!mode_ready) return;
      mode_valid = 1'b1; mode = 2'(modes_q[b]);
      @(negedge clk);
      mode_valid = 1'b0;
      for (int p = 0; p < 16; p++) begin
        if (stall) while ($urandom_range(0, 2) == 0) @(negedge clk);
        t = 0;
        while (!res_ready && t < 50) begin @(negedge clk); t++; end
        check("res_ready_wait", 32'(res_ready), 32'd1);
        if (!res_ready) return;
        if (b == abort_blk && p == 5) begin
          reset = 1'b0;
          @(posedge clk); #1;
          check("abort_pix_valid", 32'(pix_valid), 32'd0);
          check("abort_pix_data", 32'(pix_data), 32'd0);
          check("abort_pix_blk", 32'(pix_blk), 32'd0);
          check("abort_pix_pos", 32'(pix_pos), 32'd0);
          check("abort_res_ready", 32'(res_ready), 32'd0);
          check("abort_done", 32'(done_luma4x4), 32'd0);
          @(negedge clk);
          reset = 1'b1;
          return;
        end
        res_valid = 1'b1; res_data = RES_W'(res_q[b][p]); drv_hs++;
        @(negedge clk);
        res_valid = 1'b0;
      end
    end
    t = 0;
    while (done_cnt == 0 && t < 40) begin @(negedge clk); t++; end
    check("done_seen", 32'(done_cnt), 32'd1);
    @(negedge clk);
  endtask

  task automatic check_table(input int scen);
    for (int i = 0; i < NV; i++) begin
      if (vtab[i].scen == scen)
        check(vtab[i].name, 32'(cap[vtab[i].blk*16 + vtab[i].pos]), 32'(vtab[i].exp));
    end
  endtask

  function automatic int count_not(input int val);
    int n = 0;
    for (int i = 0; i < 256; i++) if (cap[i] != val) n++;
    return n;
  endfunction

  initial begin
    int bad;
    // scen 1: clipping in block 0 (DC 128)
    vtab[0]  = '{1, "clip_p200",    0, 0, 255};
    vtab[1]  = '{1, "clip_m200",    0, 1, 0};
    vtab[2]  = '{1, "clip_p127",    0, 2, 255};
    vtab[3]  = '{1, "clip_m128",    0, 3, 0};
    vtab[4]  = '{1, "clip_zero",    0, 4, 128};
    // scen 2: vertical / horizontal propagation and fallbacks
    vtab[5]  = '{2, "vert_b4_p0",   4, 0, 138};
    vtab[6]  = '{2, "vert_b4_p1",   4, 1, 148};
    vtab[7]  = '{2, "vert_b4_p2",   4, 2, 158};
    vtab[8]  = '{2, "vert_b4_p3",   4, 3, 168};
    vtab[9]  = '{2, "vert_b4_p12",  4, 12, 138};
    vtab[10] = '{2, "vert_b4_p15",  4, 15, 168};
    vtab[11] = '{2, "horiz_b1_p0",  1, 0, 128};
    vtab[12] = '{2, "horiz_b1_p12", 1, 12, 168};
    vtab[13] = '{2, "vert_notop",   2, 5, 128};
    vtab[14] = '{2, "horiz_noleft", 8, 6, 128};
    vtab[15] = '{2, "rsvd_dc_b5",   5, 0, 168};
    // scen 3: DC availability cases
    vtab[16] = '{3, "dc_b0_100",    0, 0, 100};
    vtab[17] = '{3, "dc_leftonly",  1, 7, 100};
    vtab[18] = '{3, "dc_toponly",   4, 9, 100};
    vtab[19] = '{3, "dc_both",      5, 15, 100};

    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mode_ready", 32'(mode_ready), 32'd0);
    check("rst_res_ready", 32'(res_ready), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'(pix_data), 32'd0);
    check("rst_pix_blk", 32'(pix_blk), 32'd0);
    check("rst_pix_pos", 32'(pix_pos), 32'd0);
    check("rst_done", 32'(done_luma4x4), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Flat macroblock, no stalls: latency and uniform output.
    set_flat();
    run_mb(1'b0, 16);
    check("flat_b0_p0", 32'(cap[0]), 32'd128);
    bad = count_not(128);
    check("flat_all_128", 32'(bad), 32'd0);
    check("flat_pix_count", 32'(pix_cnt), 32'd256);
    check("flat_done_count", 32'(done_cnt), 32'd1);
    // Done in cycle 305 counting the IDLE cycle that samples enable.
    check("flat_latency", 32'(done_cyc - en_cyc), 32'd303);

    set_flat();
    res_q[0][0] = 200; res_q[0][1] = -200; res_q[0][2] = 127; res_q[0][3] = -128;
    run_mb(1'b0, 16);
    check_table(1);

    set_vert_cfg();
    run_mb(1'b0, 16);
    check_table(2);
    for (int i = 0; i < 256; i++) ref_cap[i] = cap[i];

    set_dc_cfg();
    run_mb(1'b0, 16);
    check_table(3);

    // Same stream as the vertical case, with random residual gaps.
    set_vert_cfg();
    run_mb(1'b1, 16);
    bad = 0;
    for (int i = 0; i < 256; i++) if (cap[i] != ref_cap[i]) bad++;
    check("stall_stream_match", 32'(bad), 32'd0);
    check("stall_pix_vs_hs", 32'(pix_cnt), 32'(drv_hs));
    check("stall_pix_count", 32'(pix_cnt), 32'd256);
    check("stall_done_count", 32'(done_cnt), 32'd1);

    // Abort in block 6, then a fresh macroblock.
    set_dc_cfg();
    run_mb(1'b0, 6);
    repeat (30) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_idle", 32'(mode_ready), 32'd0);
    set_flat();
    run_mb(1'b0, 16);
    check("fresh_b0_p0", 32'(cap[0]), 32'd128);
    bad = count_not(128);
    check("fresh_all_128", 32'(bad), 32'd0);
    check("fresh_done_count", 32'(done_cnt), 32'd1);
    check("fresh_latency", 32'(done_cyc - en_cyc), 32'd303);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/decoder_intra4x4.md
# decoder_intra4x4

Luma intra 4x4 reconstruction for one 16x16 macroblock, decoder side: the inverse of the encoder's intra luma path. It accepts, per 4x4 block, a prediction mode and 16 dequantised, inverse-transformed residuals. It forms the intra prediction from already-reconstructed neighbours, adds the residual, clips to 8 bits and streams the reconstructed pixels out. It signals `done_luma4x4` when all 16 blocks of the macroblock are reconstructed.

## Interface
Parameters:
- `PIX_W`, 8: reconstructed sample width.
- `RES_W`, 9: signed residual width.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `enable`  in  1  start a macroblock; sampled in IDLE only.
- `mode_valid`  in  1  block header valid.
- `mode`  in  2  0 = vertical, 1 = horizontal, 2 = DC, 3 = reserved (treated as DC).
- `mode_ready`  out  1  header accepted when `mode_valid && mode_ready`.
- `res_valid`  in  1  residual valid.
- `res_data`  in  RES_W  signed residual, raster order within the block.
- `res_ready`  out  1  residual accepted when `res_valid && res_ready`.
- `pix_valid`  out  1  reconstructed pixel valid. There is no backpressure: the sink always accepts.
- `pix_data`  out  PIX_W  reconstructed pixel.
- `pix_blk`  out  4  block index of `pix_data`.
- `pix_pos`  out  4  position of `pix_data` within the block, raster order.
- `done_luma4x4`  out  1  one-cycle pulse at macroblock completion.

## Operation
- Block order is raster within the macroblock: `blk_x = idx[1:0]`, `blk_y = idx[3:2]`, with idx running 0..15.
- Internal 16x16 `PIX_W` reconstruction array. Pixels are written as they are produced and supply the neighbours for later blocks.
- Availability: top neighbours exist iff `blk_y > 0`; left neighbours exist iff `blk_x > 0`. No neighbours come from outside the macroblock.
- FSM:
  - IDLE: `enable` = 1 moves to HDR and clears idx.
  - HDR: `mode_ready` = 1. On handshake, latch the mode and move to PRED.
  - PRED: one cycle. Latch the 4 top samples T0..T3, the 4 left samples L0..L3 and the DC value. Move to RES with pos = 0.
  - RES: `res_ready` = 1. Each handshake reconstructs the pixel at pos and increments pos. Handshake 15 moves to NEXT.
  - NEXT: one cycle. If idx = 15, pulse `done_luma4x4` and go to IDLE. Otherwise increment idx and go to HDR.
- Prediction at row r, column c:
  - Vertical: T[c].
  - Horizontal: L[r].
  - DC:
    - Both top and left available: (ΣT + ΣL + 4) >> 3.
    - Top only: (ΣT + 2) >> 2.
    - Left only: (ΣL + 2) >> 2.
    - Neither: 128.
  - Vertical without top, or horizontal without left: prediction is 128. This is not an error.
- Arithmetic: the sum is pred (zero-extended) + res (sign-extended) in RES_W+1 bits, then clipped to [0, 255].
- `enable` is ignored outside IDLE. The header and residual ports are ignored outside HDR and RES respectively.

## Timing
- Reset values: `mode_ready`, `res_ready`, `pix_valid` and `done_luma4x4` are 0. `pix_data`, `pix_blk` and `pix_pos` are 0. The array is cleared, idx and pos are 0, and the FSM is in IDLE.
- Reset asserted mid-macroblock aborts immediately. No `done_luma4x4` is produced, and the partial array is discarded.
- `mode_ready` and `res_ready` are combinational decodes of the state only.
- `pix_valid`, `pix_data`, `pix_blk` and `pix_pos` are registered, one cycle after the residual handshake.
- The array write happens in the same edge as the pixel output register. The next block's PRED samples it at least 2 cycles later, so there is no hazard.
- `done_luma4x4` asserts in the NEXT cycle, i.e. the cycle in which the 256th `pix_valid` is high.
- Minimum macroblock time: 1 (IDLE→HDR) + 16 × (1 HDR + 1 PRED + 16 RES + 1 NEXT) = 305 cycles.
- Residual gaps (`res_valid` low) stall RES with no output. `pix_valid` is low in every cycle without a handshake in the previous cycle.

## Structure
- Shared package `h264_pkg`:
  - `intra4x4_mode_t` enum (VERT, HORIZ, DC, RSVD).
  - `PIX_W` and `RES_W` defaults.
  - `DC_DEFAULT` = 128.
  - The clip function.
- Sub-module `intra4x4_predictor`: purely combinational. Inputs are mode, T[4], L[4], top_avail, left_avail, r and c. Output is pred. DC is computed here and registered by the parent in PRED.
- Parent holds the FSM, counters, reconstruction array and output register.

## Test plan
- Flat MB: enable, every mode = DC, all residuals 0 → block 0 outputs 128. All 256 pixels = 128. `done_luma4x4` pulses once, 305 cycles after enable with no stalls.
- Clipping: block 0 DC, residuals +200 → 255 and −200 → 0. Residual +127 on pred 128 → 255.
- Vertical propagation: block 0 DC with residual row 3 = {10, 20, 30, 40}, others 0. Block 4 vertical with zero residuals → every row of block 4 = {138, 148, 158, 168}.
- DC left-only: block 0 all 100 (residual −28). Block 1 DC with zero residuals → 100. Block 4 DC (top only) → 100.
- Handshake stalls: random `res_valid` gaps → `pix_valid` count = accepted residuals. `pix_blk`/`pix_pos` are sequential with no gaps. The output stream is identical to the no-stall run.
- Reset mid-MB: deassert `reset` during block 6 RES → all outputs 0 next cycle and no done. A fresh MB then completes correctly, with block 0 predicting 128 regardless of prior contents.
